// File: rtl/timer_pkg.sv
// Shared constants for the Wishbone interval timer: register offsets,
// CSR bit positions and the tick divider factors.
package timer_pkg;

    localparam logic [15:0] OFF_LOAD  = 16'd0;
    localparam logic [15:0] OFF_COUNT = 16'd2;
    localparam logic [15:0] OFF_CSR   = 16'd4;

    localparam int unsigned CSR_STOP    = 32'd0;
    localparam int unsigned CSR_WRAP    = 32'd1;
    localparam int unsigned CSR_EXPEN   = 32'd2;
    localparam int unsigned CSR_ONESHOT = 32'd3;
    localparam int unsigned CSR_RUN     = 32'd4;
    localparam int unsigned CSR_DIV16   = 32'd5;
    localparam int unsigned CSR_DIV4    = 32'd6;
    localparam int unsigned CSR_EXPIRY  = 32'd7;

    // Upper CSR byte has no storage and always reads back as ones.
    localparam logic [15:0] CSR_RD_ONES = 16'hFF00;

    localparam logic [31:0] DIV16_FACTOR = 32'd16;
    localparam logic [31:0] DIV4_FACTOR  = 32'd4;

    typedef enum logic [1:0] {
        REG_LOAD  = 2'd0,
        REG_COUNT = 2'd1,
        REG_CSR   = 2'd2,
        REG_NONE  = 2'd3
    } reg_sel_e;

    function automatic logic [31:0] tick_period(input logic [31:0] prescale,
                                                input logic div16,
                                                input logic div4);
        logic [31:0] f16;
        logic [31:0] f4;
        f16 = div16 ? DIV16_FACTOR : 32'd1;
        f4  = div4  ? DIV4_FACTOR  : 32'd1;
        return prescale * f16 * f4;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides the bus clock down to a one-cycle timer tick; the period follows
// the DIV16/DIV4 selects and the count restarts on clr.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int unsigned PRESCALE = 32'd128
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic div16,
    input  logic div4,
    output logic tick
);

    logic [31:0] cnt_r;
    logic [31:0] period_s;

    assign period_s = tick_period(32'(PRESCALE), div16, div4);
    // >= keeps the divider sane if the period shrinks while mid-count.
    assign tick     = en & (cnt_r >= (period_s - 32'd1));

    // Prescale counter: holds while disabled, wraps on each tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= 32'd0;
        end else if (clr) begin
            cnt_r <= 32'd0;
        end else if (en) begin
            cnt_r <= tick ? 32'd0 : (cnt_r + 32'd1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/timer_wb.sv
// Wishbone interval timer with LOAD/COUNT/CSR registers and a level
// interrupt acknowledged by the vectored interrupt controller.
module timer_wb
    import timer_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'o177706,
    parameter int unsigned PRESCALE  = 32'd128
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [15:0] wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_sel_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic        irq_o,
    input  logic        irq_ack_i
);

    localparam logic [15:0] ADR_LOAD  = BASE_ADDR + OFF_LOAD;
    localparam logic [15:0] ADR_COUNT = BASE_ADDR + OFF_COUNT;
    localparam logic [15:0] ADR_CSR   = BASE_ADDR + OFF_CSR;

    logic [15:0] load_r;
    logic [15:0] count_r;
    logic [7:0]  csr_r;
    logic [7:0]  csr_next_s;
    logic        ack_r;
    logic        irq_r;
    reg_sel_e    reg_s;
    logic        hit_s;
    logic        wr_s;
    logic        csr_wr_lo_s;
    logic        run_rise_s;
    logic        tick_s;
    logic        zero_tick_s;
    logic        expire_s;
    logic        exp_clr_s;
    logic [15:0] rdata_s;
    logic        unused_s;

    assign unused_s = wb_adr_i[0];

    // Word address decode; byte-address bit 0 plays no part.
    always_comb begin
        if (wb_adr_i[15:1] == ADR_LOAD[15:1]) begin
            reg_s = REG_LOAD;
        end else if (wb_adr_i[15:1] == ADR_COUNT[15:1]) begin
            reg_s = REG_COUNT;
        end else if (wb_adr_i[15:1] == ADR_CSR[15:1]) begin
            reg_s = REG_CSR;
        end else begin
            reg_s = REG_NONE;
        end
    end

    assign hit_s       = wb_stb_i & (reg_s != REG_NONE);
    // Writes land only in the cycle the ack rises, so a held strobe writes once.
    assign wr_s        = hit_s & wb_we_i & ~ack_r;
    assign csr_wr_lo_s = wr_s & (reg_s == REG_CSR) & wb_sel_i[0];
    assign run_rise_s  = csr_wr_lo_s & wb_dat_i[CSR_RUN] & ~csr_r[CSR_RUN];
    assign zero_tick_s = tick_s & (count_r == 16'd0);
    assign expire_s    = zero_tick_s & csr_r[CSR_EXPEN];
    assign exp_clr_s   = (csr_wr_lo_s & ~wb_dat_i[CSR_EXPIRY]) | irq_ack_i;

    timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (wb_clk_i),
        .reset (wb_rst_i),
        .clr   (run_rise_s),
        .en    (csr_r[CSR_RUN] & ~csr_r[CSR_STOP]),
        .div16 (csr_r[CSR_DIV16]),
        .div4  (csr_r[CSR_DIV4]),
        .tick  (tick_s)
    );

    // Next CSR value: bus write beats one-shot stop; expiry set beats any clear.
    always_comb begin
        csr_next_s = csr_r;
        if (csr_wr_lo_s) begin
            csr_next_s[6:0] = wb_dat_i[6:0];
        end else if (zero_tick_s && csr_r[CSR_ONESHOT]) begin
            csr_next_s[CSR_RUN] = 1'b0;
        end else begin
            csr_next_s[6:0] = csr_r[6:0];
        end
        csr_next_s[CSR_EXPIRY] = expire_s | (csr_r[CSR_EXPIRY] & ~exp_clr_s);
    end

    // Register state, bus handshake and interrupt output.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            load_r  <= 16'd0;
            count_r <= 16'd0;
            csr_r   <= 8'd0;
            ack_r   <= 1'b0;
            irq_r   <= 1'b0;
        end else begin
            ack_r <= hit_s;
            irq_r <= csr_r[CSR_EXPIRY] & csr_r[CSR_EXPEN];
            csr_r <= csr_next_s;
            if (wr_s && (reg_s == REG_LOAD)) begin
                load_r[15:8] <= wb_sel_i[1] ? wb_dat_i[15:8] : load_r[15:8];
                load_r[7:0]  <= wb_sel_i[0] ? wb_dat_i[7:0]  : load_r[7:0];
            end else begin
                load_r <= load_r;
            end
            if (run_rise_s) begin
                count_r <= load_r;
            end else if (zero_tick_s) begin
                count_r <= csr_r[CSR_WRAP] ? 16'hFFFF : load_r;
            end else if (tick_s) begin
                count_r <= count_r - 16'd1;
            end else begin
                count_r <= count_r;
            end
        end
    end

    // Read mux; drives zero when not addressed so the bus can OR replies.
    always_comb begin
        rdata_s = 16'd0;
        if (wb_stb_i && !wb_we_i && hit_s) begin
            case (reg_s)
                REG_LOAD:  rdata_s = load_r;
                REG_COUNT: rdata_s = count_r;
                REG_CSR:   rdata_s = CSR_RD_ONES | {8'd0, csr_r};
                default:   rdata_s = 16'd0;
            endcase
        end else begin
            rdata_s = 16'd0;
        end
    end

    assign wb_dat_o = rdata_s;
    assign wb_ack_o = ack_r;
    assign irq_o    = irq_r;

endmodule

// File: doc/timer_wb.md
TIMER_WB -- requirements
Module: timer_wb

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 16'o177706, meaning the octal address of the LOAD register, with COUNT at BASE+2 and CSR at BASE+4.
REQ-002 The block SHALL have parameter PRESCALE, default 128, meaning wb_clk_i cycles per timer tick at divide-by-1.
REQ-003 wb_clk_i  input  1  bus clock; all logic sampled on its rising edge.
REQ-004 wb_rst_i  input  1  reset, synchronous, active-high.
REQ-005 wb_adr_i  input  16  byte address from the CPU bus; bit 0 is ignored.
REQ-006 wb_dat_i  input  16  write data.
REQ-007 wb_dat_o  output  16  read data; 16'd0 when the block is not selected, so the bus can OR it.
REQ-008 wb_we_i  input  1  1 = write cycle.
REQ-009 wb_sel_i  input  2  byte lanes [1]=high, [0]=low.
REQ-010 wb_stb_i  input  1  cycle strobe.
REQ-011 wb_ack_o  output  1  reply to the initiator.
REQ-012 irq_o  output  1  level interrupt request to vic_wb ireq.
REQ-013 irq_ack_i  input  1  one-cycle acknowledge pulse from vic_wb iack.

Function
REQ-014 A hit SHALL be wb_stb_i with wb_adr_i[15:1] matching one of the three register addresses; non-hits SHALL never assert wb_ack_o.
REQ-015 wb_ack_o SHALL rise one cycle after a hit is first sampled, stay high while wb_stb_i stays high, and fall one cycle after wb_stb_i falls.
REQ-016 A write SHALL take effect exactly once per strobe, in the cycle wb_ack_o rises, and only on the lanes enabled in wb_sel_i.
REQ-017 LOAD SHALL be read/write; COUNT SHALL be read-only, and writes to it SHALL be acknowledged and ignored.
REQ-018 CSR bits SHALL be: 0 STOP, 1 WRAP, 2 EXPEN, 3 ONESHOT, 4 RUN, 5 DIV16, 6 DIV4, 7 EXPIRY; bits 15:8 SHALL read as 1.
REQ-019 Tick period SHALL be PRESCALE x (DIV16?16:1) x (DIV4?4:1) clocks, from a prescaler that is cleared whenever RUN goes 0->1.
REQ-020 A RUN 0->1 write SHALL load COUNT from LOAD in the same cycle.
REQ-021 While STOP=1 or RUN=0, the prescaler and COUNT SHALL hold.
REQ-022 On a tick with COUNT!=0, COUNT SHALL decrement by 1.
REQ-023 On a tick with COUNT==0:
- EXPIRY SHALL be set if EXPEN=1.
- COUNT SHALL become 16'hFFFF if WRAP=1, else LOAD.
- RUN SHALL clear if ONESHOT=1.
REQ-024 A CSR write of 0 to bit 7 SHALL clear EXPIRY; a write of 1 to bit 7 SHALL have no effect.
REQ-025 If an expiry and an EXPIRY-clearing write occur in the same cycle, the set SHALL win.
REQ-026 irq_o SHALL equal EXPIRY & EXPEN, registered.
REQ-027 irq_ack_i SHALL clear EXPIRY; a simultaneous expiry SHALL win.
REQ-028 wb_dat_o SHALL be combinational from the address while wb_stb_i & !wb_we_i & hit; read COUNT SHALL return its current value.

Reset
REQ-029 While wb_rst_i=1: LOAD=0, COUNT=0, CSR[7:0]=0, prescaler=0, wb_ack_o=0, irq_o=0; bus cycles in progress SHALL be dropped without ack.
REQ-030 Reset mid-count SHALL stop the timer, and no tick, expiry or irq SHALL occur in the cycle reset deasserts.

Structure
REQ-031 Package timer_pkg SHALL hold the register offsets, the CSR bit indices, the CSR read-one mask 16'hFF00 and the divider factors.
REQ-032 A sub-module timer_prescaler SHALL generate the one-cycle tick from PRESCALE, DIV16, DIV4, a clear input and an enable input.

Verification
REQ-033 Write LOAD=5 then CSR=16'o000024 (RUN, EXPEN), PRESCALE=128 -> COUNT reads 4 after 128 clocks; irq_o rises after 6 ticks; CSR reads 16'o177624.
REQ-034 With WRAP|RUN and LOAD=2 -> after COUNT reaches 0, the next tick gives COUNT=16'hFFFF; with ONESHOT|RUN instead -> RUN clears, and COUNT=LOAD holds.
REQ-035 Byte write 16'hAB00 to LOAD with wb_sel_i=2'b10 over LOAD=16'h1234 -> LOAD reads 16'hAB34; a strobe held high 10 cycles writes once and acks on cycles 2-11.
REQ-036 Assert irq_ack_i in the same cycle an expiry sets EXPIRY -> EXPIRY stays 1 and irq_o stays 1; a later irq_ack_i alone -> irq_o low one cycle later.
REQ-037 Set DIV16|DIV4|RUN with LOAD=1 -> first tick after 8192 clocks; STOP=1 mid-count -> COUNT frozen; wb_rst_i pulse mid-count -> all registers read 0 except CSR=16'o177400.
